// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock FIFO with level, almost-full/almost-empty flags and sticky
//   overflow/underflow error flags.
//
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
//   (rdata shows the head word combinationally). Without it, rdata is a
//   register loaded at the edge that accepts a read (1-cycle latency).
//
// Ports
//   clk           in   rising-edge clock
//   rstn          in   asynchronous active-low reset
//   wdata         in   write data (datawidth)
//   winc          in   write request
//   rinc          in   read request
//   err_clr       in   clears overflow/underflow at the next edge
//   rdata         out  read data (datawidth)
//   wfull         out  count == DEPTH
//   rempty        out  count == 0
//   walmost_full  out  count >= afull_thresh
//   ralmost_empty out  count <= aempty_thresh
//   count         out  fill level 0..DEPTH (addr_width+1 bits)
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty (no write alongside)
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int datawidth     = 8,
  parameter int addr_width    = 3,
  parameter int afull_thresh  = 6,
  parameter int aempty_thresh = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [datawidth-1:0]  wdata,
  input  logic                  winc,
  input  logic                  rinc,
  input  logic                  err_clr,
  output logic [datawidth-1:0]  rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** addr_width;
  localparam int CW    = addr_width + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(afull_thresh);
  localparam logic [CW-1:0] AEMPTY_C = CW'(aempty_thresh);

  logic [datawidth-1:0]  mem_q [DEPTH];

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [addr_width-1:0] wr_addr;
  logic [addr_width-1:0] rd_addr;
  logic [datawidth-1:0]  head;

  // Pointers carry one extra wrap bit, so their difference is the true
  // level 0..DEPTH and full/empty never alias.
  assign count         = wr_ptr_q - rd_ptr_q;
  assign wfull         = (count == DEPTH_C);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AFULL_C);
  assign ralmost_empty = (count <= AEMPTY_C);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // Gating on the registered flags means: full + both -> read only,
  // empty + both -> write only.
  assign wr_acc  = winc & ~wfull;
  assign rd_acc  = rinc & ~rempty;
  assign wr_addr = wr_ptr_q[addr_width-1:0];
  assign rd_addr = rd_ptr_q[addr_width-1:0];
  assign head    = mem_q[rd_addr];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

    // Set beats clear when both happen on the same edge.
    if (err_clr)        overflow_d = 1'b0;
    if (winc && wfull)  overflow_d = 1'b1;

    // A read against an empty FIFO is not an error when a write is accepted
    // on the same edge; the pair simply behaves as a write.
    if (err_clr)                    underflow_d = 1'b0;
    if (rinc && rempty && !winc)    underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset; clearing the pointers discards it.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Forced to zero while empty so reset always shows rdata = 0.
  assign rdata = rempty ? '0 : head;
`else
  logic [datawidth-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = head;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule
